mult_div_unit: RTL and testbench

- E-stage HI/LO multiply/divide responder for the pipelined MIPS core.
- Accepts the E-stage control bundle (start, multctrl, muwe, mure) and operands; the core's controller drives that bundle.
- Runs mult/multu/div/divu with a fixed multi-cycle latency and exposes busy so the D-stage hazard unit stalls MU instructions (ismu).
- Holds HI/LO and serves mfhi/mflo and mthi/mtlo.

---
 rtl/mult_div_unit_pkg.sv | 40 ++++
 rtl/mult_div_unit_if.sv | 28 ++
 rtl/mult_div_unit_latency_counter.sv | 31 +++
 rtl/mult_div_unit.sv | 112 +++++++++++
 tb/tb_mult_div_unit.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared MU definitions: multctrl/muwe/mure encodings and default latencies.
// The core controller imports the same constants when it decodes MU ops.
package mult_div_unit_pkg;

   localparam int unsigned MU_DATA_W          = 32;
   localparam int unsigned MU_MULT_CYCLES_DEF = 5;
   localparam int unsigned MU_DIV_CYCLES_DEF  = 10;

   // multctrl encodings; anything outside MU_MULT..MU_DIVU is a no-op
   typedef enum logic [2:0] {
      MU_NONE  = 3'b000,
      MU_MULT  = 3'b001,
      MU_MULTU = 3'b010,
      MU_DIV   = 3'b011,
      MU_DIVU  = 3'b100
   } mu_op_e;

   // muwe / mure encodings (mure==00 reads zero, muwe==00 writes nothing)
   typedef enum logic [1:0] {
      MU_SEL_NONE = 2'b00,
      MU_SEL_LO   = 2'b01,
      MU_SEL_HI   = 2'b10
   } mu_sel_e;

   // Result held between the start edge and the commit edge
   typedef struct packed {
      logic [MU_DATA_W-1:0] phi;
      logic [MU_DATA_W-1:0] plo;
      logic                 wr;   // 0 for divide-by-zero: commit leaves HI/LO alone
   } mu_pending_t;

   function automatic logic mu_op_legal(input logic [2:0] op);
      return (op == MU_MULT) || (op == MU_MULTU) || (op == MU_DIV) || (op == MU_DIVU);
   endfunction

   function automatic logic mu_op_is_div(input logic [2:0] op);
      return (op == MU_DIV) || (op == MU_DIVU);
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage control bundle, operands and HI/LO results of the MU.
interface mu_if;
   import mult_div_unit_pkg::*;

   logic                 start;
   logic [2:0]           multctrl;
   logic [1:0]           muwe;
   logic [1:0]           mure;
   logic [MU_DATA_W-1:0] a;
   logic [MU_DATA_W-1:0] b;
   logic                 busy;
   logic [MU_DATA_W-1:0] hi;
   logic [MU_DATA_W-1:0] lo;
   logic [MU_DATA_W-1:0] mu_out;

   // controller / pipeline side
   modport master (
      output start, multctrl, muwe, mure, a, b,
      input  busy, hi, lo, mu_out
   );

   // MU side
   modport slave (
      input  start, multctrl, muwe, mure, a, b,
      output busy, hi, lo, mu_out
   );

endinterface

// File: rtl/mult_div_unit_latency_counter.sv
// Loadable down-counter: busy while nonzero, done in the last busy cycle.
module mu_latency_counter #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             busy_o,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign busy_o = (cnt_q != '0);
   assign done_o = (cnt_q == CNT_W'(1));

   // a load is only honoured when idle, so a running count is never restarted
   always_comb begin
      cnt_d = cnt_q;
      if (busy_o)      cnt_d = cnt_q - CNT_W'(1);
      else if (load_i) cnt_d = load_val_i;
   end

   // count register, synchronous active-low clear
   always_ff @(posedge clk) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage HI/LO multiply/divide unit with fixed latency.
// The result is computed in the start cycle and parked in a pending register;
// the latency counter only models the timing the hazard unit sees.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MU_MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = MU_DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   mu_if.slave  bus
);

   localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
   localparam int unsigned W       = MU_DATA_W;

   logic             busy, done, accept;
   logic [CNT_W-1:0] load_val;

   logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
   mu_pending_t    pend_q, pend_d, res;

   logic [2*W-1:0] prod_s, prod_u;
   logic           sdiv;
   logic [W-1:0]   a_mag, b_mag, dvs, q_mag, r_mag, q, r;

   // start is taken only from idle and only for a legal op
   assign accept   = bus.start && !busy && mu_op_legal(bus.multctrl);
   assign load_val = mu_op_is_div(bus.multctrl) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

   mu_latency_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .load_i    (accept),
      .load_val_i(load_val),
      .busy_o    (busy),
      .done_o    (done)
   );

   // 64-bit result for the op presented this cycle
   always_comb begin
      prod_s = {{W{bus.a[W-1]}}, bus.a} * {{W{bus.b[W-1]}}, bus.b};
      prod_u = {{W{1'b0}}, bus.a} * {{W{1'b0}}, bus.b};
      // signed divide via magnitudes: quotient truncates toward zero,
      // remainder follows the dividend; 0x80000000/-1 falls out as 0x80000000 r 0
      sdiv  = (bus.multctrl == MU_DIV);
      a_mag = (sdiv && bus.a[W-1]) ? -bus.a : bus.a;
      b_mag = (sdiv && bus.b[W-1]) ? -bus.b : bus.b;
      dvs   = (b_mag == '0) ? W'(1) : b_mag;
      q_mag = a_mag / dvs;
      r_mag = a_mag % dvs;
      q     = (sdiv && (bus.a[W-1] ^ bus.b[W-1])) ? -q_mag : q_mag;
      r     = (sdiv && bus.a[W-1]) ? -r_mag : r_mag;
      res   = '0;
      unique case (bus.multctrl)
         MU_MULT:          res = '{phi: prod_s[2*W-1:W], plo: prod_s[W-1:0], wr: 1'b1};
         MU_MULTU:         res = '{phi: prod_u[2*W-1:W], plo: prod_u[W-1:0], wr: 1'b1};
         MU_DIV, MU_DIVU:  res = '{phi: r, plo: q, wr: (bus.b != '0)};
         default:          res = '0;
      endcase
   end

   // next state of HI/LO and the pending result
   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      pend_d = pend_q;
      if (accept) pend_d = res;
      if (done) begin
         if (pend_q.wr) begin
            hi_d = pend_q.phi;
            lo_d = pend_q.plo;
         end
      end else if (!busy && !bus.start) begin
         // mthi/mtlo only from idle, and never in a start cycle
         unique case (bus.muwe)
            MU_SEL_LO: lo_d = bus.a;
            MU_SEL_HI: hi_d = bus.a;
            default:   ;
         endcase
      end
   end

   // architectural HI/LO and pending result; reset drops any in-flight op
   always_ff @(posedge clk) begin
      if (!reset) begin
         hi_q   <= '0;
         lo_q   <= '0;
         pend_q <= '0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         pend_q <= pend_d;
      end
   end

   // mfhi/mflo read port straight off the registers
   always_comb begin
      unique case (bus.mure)
         MU_SEL_LO: bus.mu_out = lo_q;
         MU_SEL_HI: bus.mu_out = hi_q;
         default:   bus.mu_out = '0;
      endcase
   end

   assign bus.busy = busy;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, arithmetic, HI/LO moves, collisions.
module tb_mult_div_unit;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   mu_if bus();

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.start = 1'b0; bus.multctrl = 3'b000; bus.muwe = 2'b00;
      bus.mure = 2'b00; bus.a = '0; bus.b = '0;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
      bus.start = 1'b1; bus.multctrl = op; bus.a = av; bus.b = bv;
      cyc();
      bus.start = 1'b0; bus.multctrl = 3'b000;
   endtask

   // counts busy cycles from the current one; bounded
   task automatic wait_idle(output int n);
      n = 0;
      while (bus.busy === 1'b1 && n < 64) begin
         n++;
         cyc();
      end
   endtask

   task automatic mt(input logic [1:0] sel, input logic [31:0] v);
      bus.muwe = sel; bus.a = v;
      cyc();
      bus.muwe = 2'b00;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b0; cyc(); cyc();
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
      checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
      bus.mure = 2'b10; #1;
      checks++; if (bus.mu_out !== 32'h0) begin failures++; $display("FAIL reset_muout got %h exp 0", bus.mu_out); end
      bus.mure = 2'b00;
      reset = 1'b1;
   endtask

   task automatic test_mult();
      int n;
      issue(3'b001, 32'hFFFF_FFFE, 32'd3);
      wait_idle(n);
      checks++; if (n != 5) begin failures++; $display("FAIL mult_busy got %0d exp 5", n); end
      checks++; if (bus.hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got %h exp ffffffff", bus.hi); end
      checks++; if (bus.lo !== 32'hFFFF_FFFA) begin failures++; $display("FAIL mult_lo got %h exp fffffffa", bus.lo); end
      bus.mure = 2'b10; #1;
      checks++; if (bus.mu_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mfhi got %h exp ffffffff", bus.mu_out); end
      bus.mure = 2'b01; #1;
      checks++; if (bus.mu_out !== 32'hFFFF_FFFA) begin failures++; $display("FAIL mflo got %h exp fffffffa", bus.mu_out); end
      bus.mure = 2'b00;
   endtask

   task automatic test_multu();
      int n;
      issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_idle(n);
      checks++; if (n != 5) begin failures++; $display("FAIL multu_busy got %0d exp 5", n); end
      checks++; if (bus.hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi got %h exp fffffffe", bus.hi); end
      checks++; if (bus.lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got %h exp 00000001", bus.lo); end
   endtask

   task automatic test_div();
      int n;
      issue(3'b011, 32'hFFFF_FFF9, 32'd2);
      wait_idle(n);
      checks++; if (n != 10) begin failures++; $display("FAIL div_busy got %0d exp 10", n); end
      checks++; if (bus.lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got %h exp fffffffd", bus.lo); end
      checks++; if (bus.hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got %h exp ffffffff", bus.hi); end
      issue(3'b100, 32'hFFFF_FFF9, 32'd2);
      wait_idle(n);
      checks++; if (n != 10) begin failures++; $display("FAIL divu_busy got %0d exp 10", n); end
      checks++; if (bus.lo !== 32'h7FFF_FFFC) begin failures++; $display("FAIL divu_lo got %h exp 7ffffffc", bus.lo); end
      checks++; if (bus.hi !== 32'h0000_0001) begin failures++; $display("FAIL divu_hi got %h exp 00000001", bus.hi); end
      issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      checks++; if (bus.lo !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_lo got %h exp 80000000", bus.lo); end
      checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL div_ovf_hi got %h exp 0", bus.hi); end
   endtask

   task automatic test_div_zero();
      int n;
      mt(2'b01, 32'h1234);
      mt(2'b10, 32'h5678);
      checks++; if (bus.lo !== 32'h1234) begin failures++; $display("FAIL mtlo got %h exp 1234", bus.lo); end
      checks++; if (bus.hi !== 32'h5678) begin failures++; $display("FAIL mthi got %h exp 5678", bus.hi); end
      issue(3'b011, 32'd5, 32'd0);
      wait_idle(n);
      checks++; if (n != 10) begin failures++; $display("FAIL divz_busy got %0d exp 10", n); end
      checks++; if (bus.hi !== 32'h5678) begin failures++; $display("FAIL divz_hi got %h exp 5678", bus.hi); end
      checks++; if (bus.lo !== 32'h1234) begin failures++; $display("FAIL divz_lo got %h exp 1234", bus.lo); end
   endtask

   task automatic test_illegal();
      bus.start = 1'b1; bus.multctrl = 3'b111; bus.a = 32'd9; bus.b = 32'd9;
      cyc();
      bus.start = 1'b0; bus.multctrl = 3'b000;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL illegal_busy got %b exp 0", bus.busy); end
      cyc();
      checks++; if (bus.hi !== 32'h5678) begin failures++; $display("FAIL illegal_hi got %h exp 5678", bus.hi); end
   endtask

   task automatic test_start_during_busy();
      int n;
      issue(3'b001, 32'd6, 32'd7);
      n = 0;
      while (bus.busy === 1'b1 && n < 64) begin
         if (n == 1) begin bus.start = 1'b1; bus.multctrl = 3'b011; bus.a = 32'd100; bus.b = 32'd3; end
         if (n == 3) begin bus.start = 1'b0; bus.multctrl = 3'b000; end
         n++;
         cyc();
      end
      checks++; if (n != 5) begin failures++; $display("FAIL restart_busy got %0d exp 5", n); end
      checks++; if (bus.lo !== 32'd42) begin failures++; $display("FAIL restart_lo got %h exp 2a", bus.lo); end
      checks++; if (bus.hi !== 32'd0) begin failures++; $display("FAIL restart_hi got %h exp 0", bus.hi); end
   endtask

   task automatic test_start_muwe();
      int n;
      bus.muwe = 2'b01;
      issue(3'b001, 32'h10, 32'h3);
      bus.muwe = 2'b00;
      checks++; if (bus.lo !== 32'd42) begin failures++; $display("FAIL startmuwe_early got %h exp 2a", bus.lo); end
      wait_idle(n);
      checks++; if (bus.lo !== 32'h30) begin failures++; $display("FAIL startmuwe_lo got %h exp 30", bus.lo); end
   endtask

   task automatic test_muwe_busy();
      int n;
      mt(2'b10, 32'hAAAA);
      issue(3'b001, 32'd3, 32'd4);
      bus.muwe = 2'b10; bus.a = 32'h5555;
      cyc(); cyc();
      checks++; if (bus.hi !== 32'hAAAA) begin failures++; $display("FAIL muwebusy_mid got %h exp aaaa", bus.hi); end
      n = 2;
      while (bus.busy === 1'b1 && n < 64) begin n++; cyc(); end
      bus.muwe = 2'b00;
      checks++; if (n != 5) begin failures++; $display("FAIL muwebusy_busy got %0d exp 5", n); end
      checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL muwebusy_hi got %h exp 0", bus.hi); end
      checks++; if (bus.lo !== 32'd12) begin failures++; $display("FAIL muwebusy_lo got %h exp c", bus.lo); end
   endtask

   task automatic test_reset_mid_op();
      mt(2'b01, 32'hBEEF);
      mt(2'b10, 32'hCAFE);
      issue(3'b001, 32'd5, 32'd7);
      cyc(); cyc();
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
      checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL rstmid_hi got %h exp 0", bus.hi); end
      checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL rstmid_lo got %h exp 0", bus.lo); end
      repeat (8) cyc();
      checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL rstmid_late_lo got %h exp 0", bus.lo); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_late_busy got %b exp 0", bus.busy); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_div_zero();
      test_illegal();
      test_start_during_busy();
      test_start_muwe();
      test_muwe_busy();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
